// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter sharing one memory get/put port.
// Issued requests are tagged so responses return to their client in order.
module mem_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned REQ_W = 68
) (
    input  logic             CLK,
    input  logic             RST,

    input  logic             c0_put_enable,
    output logic             c0_put_ready,
    input  logic [REQ_W-1:0] c0_put_request,
    input  logic             c0_get_enable,
    output logic             c0_get_ready,
    output logic [REQ_W-1:0] c0_get_response,

    input  logic             c1_put_enable,
    output logic             c1_put_ready,
    input  logic [REQ_W-1:0] c1_put_request,
    input  logic             c1_get_enable,
    output logic             c1_get_ready,
    output logic [REQ_W-1:0] c1_get_response,

    output logic             m_put_enable,
    input  logic             m_put_ready,
    output logic [REQ_W-1:0] m_put_request,
    output logic             m_get_enable,
    input  logic             m_get_ready,
    input  logic [REQ_W-1:0] m_get_response
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    // Per-client request and response buffers
    logic [1:0]       rq_vld_q, rq_vld_d;
    logic [REQ_W-1:0] rq_data_q [2];
    logic [REQ_W-1:0] rq_data_d [2];
    logic [1:0]       rs_vld_q, rs_vld_d;
    logic [REQ_W-1:0] rs_data_q [2];
    logic [REQ_W-1:0] rs_data_d [2];

    // Tag FIFO recording which client owns each outstanding request
    logic [DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;

    logic [1:0]       put_en;
    logic [1:0]       get_en;
    logic [REQ_W-1:0] put_req [2];
    logic             tag_full;
    logic             issue;
    logic             grant;
    logic             head_tag;
    logic             ret;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign put_en     = {c1_put_enable, c0_put_enable};
    assign get_en     = {c1_get_enable, c0_get_enable};
    assign put_req[0] = c0_put_request;
    assign put_req[1] = c1_put_request;

    // Count check uses the registered value, so a same-cycle pop does not unblock issue
    assign tag_full = (cnt_q == CNT_W'(DEPTH));
    assign issue    = !RST && (rq_vld_q != 2'b00) && m_put_ready && !tag_full;
    assign grant    = (&rq_vld_q) ? prio_q : rq_vld_q[1];
    assign head_tag = tag_q[rd_ptr_q];
    assign ret      = !RST && m_get_ready && (cnt_q != '0) && !rs_vld_q[head_tag];

    assign c0_put_ready    = !RST && !rq_vld_q[0];
    assign c1_put_ready    = !RST && !rq_vld_q[1];
    assign c0_get_ready    = !RST && rs_vld_q[0];
    assign c1_get_ready    = !RST && rs_vld_q[1];
    assign c0_get_response = rs_data_q[0];
    assign c1_get_response = rs_data_q[1];
    assign m_put_enable    = issue;
    assign m_put_request   = rq_data_q[grant];
    assign m_get_enable    = ret;

    always_comb begin
        rq_vld_d  = rq_vld_q;
        rq_data_d = rq_data_q;
        rs_vld_d  = rs_vld_q;
        rs_data_d = rs_data_q;
        tag_d     = tag_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;

        for (int i = 0; i < 2; i++) begin
            if (put_en[i] && !rq_vld_q[i]) begin
                rq_vld_d[i]  = 1'b1;
                rq_data_d[i] = put_req[i];
            end
            if (get_en[i] && rs_vld_q[i]) begin
                rs_vld_d[i] = 1'b0;
            end
        end

        if (issue) begin
            rq_vld_d[grant] = 1'b0;
            tag_d[wr_ptr_q] = grant;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
            prio_d          = !grant;
        end

        if (ret) begin
            rs_vld_d[head_tag]  = 1'b1;
            rs_data_d[head_tag] = m_get_response;
            rd_ptr_d            = ptr_inc(rd_ptr_q);
        end

        case ({issue, ret})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rq_vld_q <= '0;
            rs_vld_q <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            prio_q   <= 1'b0;
        end else begin
            rq_vld_q <= rq_vld_d;
            rs_vld_q <= rs_vld_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            prio_q   <= prio_d;
        end
    end

    // Payload registers are qualified by the valid bits and need no reset
    always_ff @(posedge CLK) begin
        rq_data_q <= rq_data_d;
        rs_data_q <= rs_data_d;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a latency memory model plus per-client
// expected-response queues filled on put and drained on get.
module tb_mem_arbiter;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned REQ_W = 68;

    typedef logic [REQ_W-1:0] word_t;

    logic  CLK;
    logic  RST;
    logic  c0_put_enable, c0_put_ready, c0_get_enable, c0_get_ready;
    logic  c1_put_enable, c1_put_ready, c1_get_enable, c1_get_ready;
    word_t c0_put_request, c0_get_response, c1_put_request, c1_get_response;
    logic  m_put_enable, m_put_ready, m_get_enable, m_get_ready;
    word_t m_put_request, m_get_response;

    mem_arbiter #(.DEPTH(DEPTH), .REQ_W(REQ_W)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .c0_put_enable   (c0_put_enable),
        .c0_put_ready    (c0_put_ready),
        .c0_put_request  (c0_put_request),
        .c0_get_enable   (c0_get_enable),
        .c0_get_ready    (c0_get_ready),
        .c0_get_response (c0_get_response),
        .c1_put_enable   (c1_put_enable),
        .c1_put_ready    (c1_put_ready),
        .c1_put_request  (c1_put_request),
        .c1_get_enable   (c1_get_enable),
        .c1_get_ready    (c1_get_ready),
        .c1_get_response (c1_get_response),
        .m_put_enable    (m_put_enable),
        .m_put_ready     (m_put_ready),
        .m_put_request   (m_put_request),
        .m_get_enable    (m_get_enable),
        .m_get_ready     (m_get_ready),
        .m_get_response  (m_get_response)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int    n_vec = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    mem_lat = 2;
    bit    mem_ret_en = 1'b1;
    bit    auto_c0 = 1'b1;
    bit    auto_c1 = 1'b1;
    word_t exp0 [$];
    word_t exp1 [$];
    word_t mem_w [$];
    int    mem_due [$];

    logic  sn_pr0, sn_pr1, sn_gr0, sn_gr1, sn_mpe, sn_mge;
    word_t sn_mreq, sn_rsp0;

    task automatic check_val(input string tag, input word_t got, input word_t exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Word layout {byte_en, addr, data}; data[31] names the issuing client
    function automatic word_t mk(input bit cl, input int idx, input logic [31:0] addr);
        return {4'hF, addr, cl, 31'(idx)};
    endfunction

    task automatic mem_drive();
        if (mem_w.size() > 0) begin
            m_get_response = mem_w[0];
            m_get_ready    = mem_ret_en && (mem_due[0] <= cyc);
        end else begin
            m_get_response = '0;
            m_get_ready    = 1'b0;
        end
    endtask

    // Observe the current cycle mid-period, then advance to the next one
    task automatic cyc_end();
        @(negedge CLK);
        sn_pr0  = c0_put_ready;
        sn_pr1  = c1_put_ready;
        sn_gr0  = c0_get_ready;
        sn_gr1  = c1_get_ready;
        sn_mpe  = m_put_enable;
        sn_mge  = m_get_enable;
        sn_mreq = m_put_request;
        sn_rsp0 = c0_get_response;
        if (!RST) begin
            if (c0_put_enable && c0_put_ready) exp0.push_back(c0_put_request);
            if (c1_put_enable && c1_put_ready) exp1.push_back(c1_put_request);
            if (m_put_enable && m_put_ready) begin
                mem_w.push_back(m_put_request);
                mem_due.push_back(cyc + mem_lat);
            end
            if (m_get_enable) begin
                if (mem_w.size() == 0) begin
                    check_val("mem_underflow", word_t'(1), word_t'(0));
                end else begin
                    void'(mem_w.pop_front());
                    void'(mem_due.pop_front());
                end
            end
            if (c0_get_enable && c0_get_ready) begin
                if (exp0.size() == 0) check_val("rsp0_unexpected", c0_get_response, '0);
                else check_val("rsp0", c0_get_response, exp0.pop_front());
            end
            if (c1_get_enable && c1_get_ready) begin
                if (exp1.size() == 0) check_val("rsp1_unexpected", c1_get_response, '0);
                else check_val("rsp1", c1_get_response, exp1.pop_front());
            end
        end
        @(posedge CLK);
        #1;
        cyc++;
        mem_drive();
        #1;
        c0_get_enable = auto_c0 && c0_get_ready;
        c1_get_enable = auto_c1 && c1_get_ready;
    endtask

    task automatic put(input bit cl, input word_t w);
        int k = 0;
        while (((cl == 1'b0) ? c0_put_ready : c1_put_ready) == 1'b0 && k < 20) begin
            cyc_end();
            k++;
        end
        if (k >= 20) check_val("put_ready_timeout", word_t'(0), word_t'(1));
        if (cl == 1'b0) begin
            c0_put_enable  = 1'b1;
            c0_put_request = w;
        end else begin
            c1_put_enable  = 1'b1;
            c1_put_request = w;
        end
        cyc_end();
        c0_put_enable = 1'b0;
        c1_put_enable = 1'b0;
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (k < 200 && (exp0.size() + exp1.size() + mem_w.size()) != 0) begin
            cyc_end();
            k++;
        end
        check_val(tag, word_t'(exp0.size() + exp1.size() + mem_w.size()), '0);
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        exp0.delete();
        exp1.delete();
        mem_w.delete();
        mem_due.delete();
        mem_drive();
        for (int i = 0; i < n; i++) cyc_end();
        RST = 1'b0;
    endtask

    initial begin
        word_t w, w0, w1;
        int    nis;
        int    ng;
        int    i0;
        int    i1;
        int    k;
        int    nmge;
        bit    third;

        RST            = 1'b1;
        c0_put_enable  = 1'b0;
        c1_put_enable  = 1'b0;
        c0_get_enable  = 1'b0;
        c1_get_enable  = 1'b0;
        c0_put_request = '0;
        c1_put_request = '0;
        m_put_ready    = 1'b1;
        mem_drive();

        // Reset with enables toggling: every ready and enable held low
        for (int i = 0; i < 3; i++) begin
            c0_put_enable = i[0];
            c1_put_enable = !i[0];
            c0_put_request = mk(1'b0, i, 32'h40);
            c1_put_request = mk(1'b1, i, 32'h44);
            cyc_end();
            check_val("rst_outs", word_t'({sn_pr0, sn_pr1, sn_gr0, sn_gr1, sn_mpe, sn_mge}), '0);
        end
        c0_put_enable = 1'b0;
        c1_put_enable = 1'b0;
        RST = 1'b0;
        cyc_end();
        check_val("post_rst_outs", word_t'({sn_pr0, sn_pr1, sn_gr0, sn_gr1, sn_mpe, sn_mge}),
                  word_t'(6'b110000));

        // Single client read, memory latency such that return is at t+3
        w = mk(1'b0, 1, 32'h100);
        c0_put_enable  = 1'b1;
        c0_put_request = w;
        cyc_end();
        c0_put_enable = 1'b0;
        check_val("single_put_ready", word_t'(sn_pr0), word_t'(1));
        cyc_end();
        check_val("single_issue", word_t'(sn_mpe), word_t'(1));
        check_val("single_word", sn_mreq, w);
        cyc_end();
        check_val("single_no_ret_early", word_t'(sn_mge), word_t'(0));
        cyc_end();
        check_val("single_ret", word_t'(sn_mge), word_t'(1));
        cyc_end();
        check_val("single_get_ready", word_t'(sn_gr0), word_t'(1));
        check_val("single_rsp", sn_rsp0, w);
        check_val("single_c1_idle", word_t'(sn_gr1), word_t'(0));
        drain("single_drain");

        // Contention from a fresh reset: prio starts at client 0
        do_reset(2);
        w0 = mk(1'b0, 2, 32'h180);
        w1 = mk(1'b1, 3, 32'h1C0);
        c0_put_enable = 1'b1; c0_put_request = w0;
        c1_put_enable = 1'b1; c1_put_request = w1;
        cyc_end();
        c0_put_enable = 1'b0;
        c1_put_enable = 1'b0;
        cyc_end();
        check_val("cont_first_issue", word_t'(sn_mpe), word_t'(1));
        check_val("cont_first_word", sn_mreq, w0);
        cyc_end();
        check_val("cont_second_issue", word_t'(sn_mpe), word_t'(1));
        check_val("cont_second_word", sn_mreq, w1);
        drain("cont_drain");

        // Both clients re-putting whenever ready: grants alternate 0,1,0,1
        ng = 0; i0 = 0; i1 = 0; k = 0;
        while (ng < 8 && k < 80) begin
            c0_put_enable  = c0_put_ready;
            c0_put_request = mk(1'b0, 100 + i0, 32'h200);
            c1_put_enable  = c1_put_ready;
            c1_put_request = mk(1'b1, 200 + i1, 32'h300);
            cyc_end();
            if (c0_put_enable && sn_pr0) i0++;
            if (c1_put_enable && sn_pr1) i1++;
            if (sn_mpe) begin
                check_val("alt_grant", word_t'(sn_mreq[31]), word_t'(ng % 2));
                ng++;
            end
            k++;
        end
        c0_put_enable = 1'b0;
        c1_put_enable = 1'b0;
        if (ng < 8) check_val("alt_timeout", word_t'(ng), word_t'(8));
        drain("alt_drain");

        // Outstanding limit: memory holds its responses
        mem_ret_en = 1'b0;
        mem_drive();
        nis = 0;
        third = 1'b0;
        c0_put_enable = 1'b1; c0_put_request = mk(1'b0, 300, 32'h400);
        c1_put_enable = 1'b1; c1_put_request = mk(1'b1, 301, 32'h404);
        cyc_end();
        nis += int'(sn_mpe);
        c0_put_enable = 1'b0;
        c1_put_enable = 1'b0;
        w = mk(1'b0, 302, 32'h408);
        for (int i = 0; i < 6; i++) begin
            if (!third && c0_put_ready) begin
                c0_put_enable  = 1'b1;
                c0_put_request = w;
                third = 1'b1;
            end else begin
                c0_put_enable = 1'b0;
            end
            cyc_end();
            nis += int'(sn_mpe);
        end
        c0_put_enable = 1'b0;
        check_val("lim_issue_count", word_t'(nis), word_t'(2));
        check_val("lim_third_buffered", word_t'(sn_pr0), word_t'(0));
        mem_ret_en = 1'b1;
        mem_drive();
        cyc_end();
        check_val("lim_return", word_t'(sn_mge), word_t'(1));
        check_val("lim_still_blocked", word_t'(sn_mpe), word_t'(0));
        cyc_end();
        check_val("lim_third_issue", word_t'(sn_mpe), word_t'(1));
        check_val("lim_third_word", sn_mreq, w);
        drain("lim_drain");

        // Head-of-line: c0 holds its first response, tags are c0,c0,c1
        auto_c0 = 1'b0;
        c0_get_enable = 1'b0;
        put(1'b0, mk(1'b0, 400, 32'h500));
        put(1'b0, mk(1'b0, 401, 32'h504));
        put(1'b1, mk(1'b1, 402, 32'h508));
        nmge = 0;
        for (int i = 0; i < 8; i++) begin
            cyc_end();
            nmge += int'(sn_mge);
        end
        check_val("hol_no_return", word_t'(nmge), word_t'(0));
        check_val("hol_c0_full", word_t'(sn_gr0), word_t'(1));
        check_val("hol_c1_empty", word_t'(sn_gr1), word_t'(0));
        auto_c0 = 1'b1;
        drain("hol_drain");

        // Reset mid-flight with two tags outstanding and both buffers full
        auto_c0 = 1'b0;
        auto_c1 = 1'b0;
        c0_get_enable = 1'b0;
        c1_get_enable = 1'b0;
        put(1'b0, mk(1'b0, 500, 32'h600));
        put(1'b1, mk(1'b1, 501, 32'h604));
        put(1'b0, mk(1'b0, 502, 32'h608));
        put(1'b1, mk(1'b1, 503, 32'h60C));
        for (int i = 0; i < 8; i++) cyc_end();
        check_val("mid_both_full", word_t'({sn_gr0, sn_gr1}), word_t'(2'b11));
        check_val("mid_blocked", word_t'(sn_mge), word_t'(0));
        do_reset(2);
        auto_c0 = 1'b1;
        auto_c1 = 1'b1;
        cyc_end();
        check_val("mid_post_rst", word_t'({sn_pr0, sn_pr1, sn_gr0, sn_gr1, sn_mge}),
                  word_t'(5'b11000));
        put(1'b0, mk(1'b0, 504, 32'h700));
        drain("mid_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
